// File: rtl/avalon_seq_master.sv
// -----------------------------------------------------------------------------
// avalon_seq_master
//   Command-driven Avalon-MM master that moves a block of sequential words
//   between a valid/ready stream and an on-chip RAM slave (read latency 1).
//
//   Ports
//     clk, reset          : rising-edge clock, asynchronous active-high reset
//     cmd_*               : block command (write/read, start address, length)
//     wr_valid/ready/data : write-data stream drained into the RAM
//     rd_valid/ready/data : read-data stream fed from a 2-entry buffer
//     busy, done          : command in progress / one-cycle completion pulse
//     avm_*               : Avalon-MM master port towards the RAM slave
// -----------------------------------------------------------------------------
module avalon_seq_master #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     avm_address,
  output logic                  avm_chipselect,
  output logic                  avm_read,
  output logic                  avm_write,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  output logic [DATA_W-1:0]     avm_writedata,
  input  logic [DATA_W-1:0]     avm_readdata,
  input  logic                  avm_waitrequest
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    remain_q, remain_d;   // words still to be issued
  logic                write_q, write_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                inflight_q, inflight_d;
  logic [1:0]          fifo_cnt_q, fifo_cnt_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic [DATA_W-1:0]   fifo_mem [2];

  logic                push, pop, beat;
  logic                read_req, read_acc, write_acc;
  logic [1:0]          slots_used;

  // Buffer bookkeeping and read-issue decision.
  always_comb begin
    push       = inflight_q;
    pop        = (fifo_cnt_q != 2'd0) && rd_ready;
    // A word popped this cycle frees its slot right away, which is what lets
    // a 2-entry buffer sustain one read per cycle without ever overflowing.
    slots_used = fifo_cnt_q - {1'b0, pop} + {1'b0, inflight_q};
    read_req   = (state_q == S_READ) && (remain_q != '0) && (slots_used < 2'd2);
    read_acc   = read_req && !avm_waitrequest;
    write_acc  = write_q && !avm_waitrequest;
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    inflight_d = read_acc;
    fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
    rd_ptr_d   = pop  ? ~rd_ptr_q : rd_ptr_q;
    wr_ptr_d   = push ? ~wr_ptr_q : wr_ptr_q;
    cmd_ready  = 1'b0;
    wr_ready   = 1'b0;
    done       = 1'b0;
    beat       = 1'b0;

    // Address wraps naturally at 2**ADDR_W.
    if (read_acc || write_acc) addr_d = addr_q + ADDR_W'(1);

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d   = cmd_addr;
          remain_d = cmd_len;
          if (cmd_len == '0)  state_d = S_DONE;
          else if (cmd_write) state_d = S_WRITE;
          else                state_d = S_READ;
        end
      end
      S_WRITE: begin
        // In write mode the counter tracks beats taken from the stream, so a
        // beat is only accepted when a bus slot for it is guaranteed.
        wr_ready = (remain_q != '0) && (!write_q || !avm_waitrequest);
        beat     = wr_valid && wr_ready;
        if (beat) begin
          write_d  = 1'b1;
          wdata_d  = wr_data;
          remain_d = remain_q - LEN_W'(1);
        end else if (write_acc) begin
          write_d = 1'b0;
        end
        if ((remain_q == '0) && write_acc) state_d = S_DONE;
      end
      S_READ: begin
        if (read_acc) begin
          remain_d = remain_q - LEN_W'(1);
          if (remain_q == LEN_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!inflight_q && (fifo_cnt_q == 2'd0)) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      inflight_q <= 1'b0;
      fifo_cnt_q <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge value regardless of statement order.
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      inflight_q <= inflight_d;
      fifo_cnt_q <= fifo_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // NOTE: buffer storage is not reset; the count and pointers decide what is
  // valid, so clearing the data would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= avm_readdata;
  end

  assign avm_address    = addr_q;
  assign avm_read       = read_req;
  assign avm_write      = write_q;
  assign avm_chipselect = read_req | write_q;
  assign avm_byteenable = '1;
  assign avm_writedata  = wdata_q;
  assign rd_valid       = (fifo_cnt_q != 2'd0);
  assign rd_data        = fifo_mem[rd_ptr_q];
  assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_avalon_seq_master.sv
// -----------------------------------------------------------------------------
// tb_avalon_seq_master
//   Directed bench for avalon_seq_master with a latency-1 RAM model.
//   Expected bus writes and read-stream words are queued when stimulus is
//   issued; a negedge monitor pops and compares whenever the DUT presents them.
// -----------------------------------------------------------------------------
module tb_avalon_seq_master;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_exp_t;

  logic        clk;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [9:0]  cmd_addr;
  logic [10:0] cmd_len;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid, rd_ready;
  logic [31:0] rd_data;
  logic        busy, done;
  logic [9:0]  avm_address;
  logic        avm_chipselect, avm_read, avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata, avm_readdata;
  logic        avm_waitrequest;

  int checks_total  = 0;
  int checks_passed = 0;
  int wr_acc_cnt    = 0;
  int rd_acc_cnt    = 0;
  int rd_seen       = 0;

  wr_exp_t     exp_wr[$];
  logic [31:0] exp_rd[$];
  logic [31:0] ram [1024];

  avalon_seq_master dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_write       (cmd_write),
    .cmd_addr        (cmd_addr),
    .cmd_len         (cmd_len),
    .wr_valid        (wr_valid),
    .wr_ready        (wr_ready),
    .wr_data         (wr_data),
    .rd_valid        (rd_valid),
    .rd_ready        (rd_ready),
    .rd_data         (rd_data),
    .busy            (busy),
    .done            (done),
    .avm_address     (avm_address),
    .avm_chipselect  (avm_chipselect),
    .avm_read        (avm_read),
    .avm_write       (avm_write),
    .avm_byteenable  (avm_byteenable),
    .avm_writedata   (avm_writedata),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Latency-1 RAM slave model.
  always @(posedge clk) begin
    if (avm_write && !avm_waitrequest) ram[avm_address] <= avm_writedata;
    if (avm_read && !avm_waitrequest)  avm_readdata <= ram[avm_address];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin : monitor
    wr_exp_t     we;
    logic [31:0] re;
    check("rw_exclusive", 64'(avm_read & avm_write), 64'd0);
    if (avm_write && !avm_waitrequest) begin
      wr_acc_cnt++;
      if (exp_wr.size() == 0) check("wr_unexpected", 64'd1, 64'd0);
      else begin
        we = exp_wr.pop_front();
        check("wr_addr", 64'(avm_address), 64'(we.addr));
        check("wr_data", 64'(avm_writedata), 64'(we.data));
      end
    end
    if (avm_read && !avm_waitrequest) rd_acc_cnt++;
    if (rd_valid && rd_ready) begin
      rd_seen++;
      if (exp_rd.size() == 0) check("rd_unexpected", 64'd1, 64'd0);
      else begin
        re = exp_rd.pop_front();
        check("rd_data", 64'(rd_data), 64'(re));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    check({tag, "_avm_ctrl"},  64'({avm_read, avm_write, avm_chipselect}), 64'd0);
    check({tag, "_avm_addr"},  64'(avm_address), 64'd0);
    check({tag, "_byteen"},    64'(avm_byteenable), 64'hF);
    check({tag, "_wr_ready"},  64'(wr_ready), 64'd0);
    check({tag, "_rd_valid"},  64'(rd_valid), 64'd0);
    check({tag, "_busy_done"}, 64'({busy, done}), 64'd0);
  endtask

  // Called at posedge+1; returns at posedge+1 of the first cycle after accept.
  task automatic issue_cmd(input logic wr, input logic [9:0] a, input logic [10:0] l);
    logic ok;
    int   n;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l;
    ok = 1'b0; n = 0;
    while (!ok && n < 20) begin
      @(negedge clk); ok = cmd_ready;
      @(posedge clk); #1; n++;
    end
    if (!ok) check("cmd_accept_timeout", 64'd0, 64'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic feed(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      logic acc;
      int   tries;
      wr_data = base + 32'(i); wr_valid = 1'b1;
      acc = 1'b0; tries = 0;
      while (!acc && tries < 50) begin
        @(negedge clk); acc = wr_ready;
        @(posedge clk); #1; tries++;
      end
      if (!acc) begin
        check("wr_beat_timeout", 64'd0, 64'd1);
        break;
      end
    end
    wr_valid = 1'b0;
  endtask

  // Samples one bit per cycle starting with the cycle after the accept edge.
  task automatic record(input int n, output logic [15:0] wv, output logic [15:0] rv,
                        output logic [15:0] vv, output logic [15:0] dv, output logic [15:0] bv);
    wv = '0; rv = '0; vv = '0; dv = '0; bv = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wv[i] = avm_write; rv[i] = avm_read; vv[i] = rd_valid; dv[i] = done; bv[i] = busy;
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input string name, input int max);
    logic got;
    got = 1'b0;
    for (int n = 0; n < max && !got; n++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    check({name, "_done"}, 64'(got), 64'd1);
    @(negedge clk);
    check({name, "_idle_after"}, 64'({busy, cmd_ready}), 64'b01);
    @(posedge clk); #1;
  endtask

  initial begin : stim
    logic [15:0] wv, rv, vv, dv, bv;
    int base_rd, base_wr, base_seen, n;

    reset = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0; avm_waitrequest = 1'b0;
    #1 reset = 1'b1;
    #2 check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Write 4 words at 0x010, full rate.
    for (int i = 0; i < 4; i++) exp_wr.push_back({10'h010 + 10'(i), 32'hA0 + 32'(i)});
    fork
      feed(4, 32'hA0);
      begin
        issue_cmd(1'b1, 10'h010, 11'd4);
        record(8, wv, rv, vv, dv, bv);
      end
    join
    check("w4_write_cycles", 64'(wv), 64'h001E);
    check("w4_done_cycle",   64'(dv), 64'h0020);
    check("w4_busy_cycles",  64'(bv), 64'h003F);

    // Read the 4 words back with rd_ready held high.
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_rd.push_back(32'hA0 + 32'(i));
    issue_cmd(1'b0, 10'h010, 11'd4);
    record(10, wv, rv, vv, dv, bv);
    check("r4_read_cycles",  64'(rv), 64'h000F);
    check("r4_valid_cycles", 64'(vv), 64'h003C);
    check("r4_done_cycle",   64'(dv), 64'h0080);
    check("r4_sb_empty",     64'(exp_rd.size()), 64'd0);

    // Zero-length command.
    issue_cmd(1'b1, 10'h050, 11'd0);
    record(4, wv, rv, vv, dv, bv);
    check("noop_bus_idle", 64'({wv, rv}), 64'd0);
    check("noop_done",     64'(dv), 64'h0001);
    check("noop_busy",     64'(bv), 64'h0001);

    // Full-RAM write from 0x200: data 0x5000_0000 + i, addresses wrap.
    for (int i = 0; i < 1024; i++) exp_wr.push_back({10'h200 + 10'(i), 32'h5000_0000 + 32'(i)});
    base_wr = wr_acc_cnt;
    fork
      feed(1024, 32'h5000_0000);
      issue_cmd(1'b1, 10'h200, 11'd1024);
    join
    wait_done("w1024", 40);
    check("w1024_count",    64'(wr_acc_cnt - base_wr), 64'd1024);
    check("w1024_addr_end", 64'(avm_address), 64'h200);

    // Read across the wrap point: ram[0x3FF] = +0x1FF, ram[0x000] = +0x200.
    exp_rd.push_back(32'h5000_01FF);
    exp_rd.push_back(32'h5000_0200);
    issue_cmd(1'b0, 10'h3FF, 11'd2);
    wait_done("rwrap", 20);

    // Backpressured read of 8 words from 0x100 (ram = 0x5000_0300 + i).
    rd_ready = 1'b0;
    for (int i = 0; i < 8; i++) exp_rd.push_back(32'h5000_0300 + 32'(i));
    base_rd = rd_acc_cnt; base_seen = rd_seen;
    issue_cmd(1'b0, 10'h100, 11'd8);
    repeat (10) @(negedge clk);
    check("bp_reads_issued", 64'(rd_acc_cnt - base_rd), 64'd2);
    check("bp_fifo_holding", 64'({rd_valid, avm_read}), 64'b10);
    @(posedge clk); #1;
    rd_ready = 1'b1;
    wait_done("bp", 40);
    check("bp_words_out", 64'(rd_seen - base_seen), 64'd8);
    check("bp_sb_empty",  64'(exp_rd.size()), 64'd0);

    // Write 3 words at 0x3FE, stall the 2nd for 2 cycles.
    exp_wr.push_back({10'h3FE, 32'hC0});
    exp_wr.push_back({10'h3FF, 32'hC1});
    exp_wr.push_back({10'h000, 32'hC2});
    fork
      feed(3, 32'hC0);
      begin
        logic seen;
        issue_cmd(1'b1, 10'h3FE, 11'd3);
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
          @(negedge clk);
          if (avm_write && avm_address == 10'h3FE) seen = 1'b1;
        end
        check("stall_first_write", 64'(seen), 64'd1);
        @(posedge clk); #1;
        avm_waitrequest = 1'b1;
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          check("stall_addr",  64'(avm_address), 64'h3FF);
          check("stall_data",  64'(avm_writedata), 64'hC1);
          check("stall_ctrl",  64'({avm_write, avm_chipselect, avm_read}), 64'b110);
          check("stall_wr_rdy", 64'(wr_ready), 64'd0);
          @(posedge clk); #1;
        end
        avm_waitrequest = 1'b0;
      end
    join
    wait_done("stall", 20);
    check("stall_sb_empty", 64'(exp_wr.size()), 64'd0);

    // Reset while the 5th word of a 16-word read is presented.
    for (int i = 0; i < 4; i++) exp_rd.push_back(32'h5000_0300 + 32'(i));
    base_seen = rd_seen;
    issue_cmd(1'b0, 10'h100, 11'd16);
    n = 0;
    while ((rd_seen - base_seen) < 4 && n < 30) begin
      @(posedge clk); #2; n++;
    end
    check("abort_4_words_seen", 64'(rd_seen - base_seen), 64'd4);
    reset = 1'b1;
    #1 check_reset_outputs("abort");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    dv = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); dv[i] = done | busy;
    end
    check("abort_no_done", 64'(dv), 64'd0);
    check("abort_sb_empty", 64'(exp_rd.size()), 64'd0);
    @(posedge clk); #1;

    // Following 2-word read runs normally: ram[0x3FE]=0xC0, ram[0x3FF]=0xC1.
    exp_rd.push_back(32'hC0);
    exp_rd.push_back(32'hC1);
    issue_cmd(1'b0, 10'h3FE, 11'd2);
    wait_done("post_abort", 20);

    check("final_wr_sb_empty", 64'(exp_wr.size()), 64'd0);
    check("final_rd_sb_empty", 64'(exp_rd.size()), 64'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
